// File: rtl/karatsuba_mul_10b.sv
// rtl/karatsuba_mul_10b.sv - sequential 10x10 unsigned Karatsuba multiplier, start/done handshake
// Optional KARATSUBA_PARALLEL_EN: three 6x6 multipliers in one MULP state instead of one shared multiplier.
module karatsuba_mul_10b (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic [19:0] s,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL2, MULM, MULP, SUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  a_q, a_d, b_q, b_d;
  logic [9:0]  z0_q, z0_d, z2_q, z2_d;
  logic [11:0] p_q, p_d;
  logic [19:0] s_q, s_d;
  logic        done_q, done_d;

  logic [5:0]  a_mid, b_mid;
  logic [11:0] z1;
  logic [19:0] sum_w;

  assign a_mid = {1'b0, a_q[9:5]} + {1'b0, a_q[4:0]};
  assign b_mid = {1'b0, b_q[9:5]} + {1'b0, b_q[4:0]};

  // z1 is non-negative by construction, so 12-bit wrap-free subtraction is exact
  assign z1    = p_q - {2'b00, z2_q} - {2'b00, z0_q};
  assign sum_w = {z2_q, 10'b0} + {3'b000, z1, 5'b0} + {10'b0, z0_q};

`ifdef KARATSUBA_PARALLEL_EN
  logic [11:0] prod_lo, prod_hi, prod_mid;
  assign prod_lo  = {1'b0, a_q[4:0]} * {1'b0, b_q[4:0]};
  assign prod_hi  = {1'b0, a_q[9:5]} * {1'b0, b_q[9:5]};
  assign prod_mid = a_mid * b_mid;
`else
  logic [5:0]  mul_x, mul_y;
  logic [11:0] mul_out;

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL0: begin mul_x = {1'b0, a_q[4:0]}; mul_y = {1'b0, b_q[4:0]}; end
      MUL2: begin mul_x = {1'b0, a_q[9:5]}; mul_y = {1'b0, b_q[9:5]}; end
      MULM: begin mul_x = a_mid;            mul_y = b_mid;            end
      default: ;
    endcase
  end

  assign mul_out = mul_x * mul_y;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    p_d     = p_q;
    s_d     = s_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          done_d = 1'b0;
`ifdef KARATSUBA_PARALLEL_EN
          state_d = MULP;
`else
          state_d = MUL0;
`endif
        end
      end
`ifdef KARATSUBA_PARALLEL_EN
      MULP: begin
        z0_d    = prod_lo[9:0];
        z2_d    = prod_hi[9:0];
        p_d     = prod_mid;
        state_d = SUM;
      end
`else
      MUL0: begin z0_d = mul_out[9:0]; state_d = MUL2; end
      MUL2: begin z2_d = mul_out[9:0]; state_d = MULM; end
      MULM: begin p_d  = mul_out;      state_d = SUM;  end
`endif
      SUM: begin
        s_d     = sum_w;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      p_q     <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      p_q     <= p_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  assign s    = s_q;
  assign done = done_q;

endmodule

// File: tb/tb_karatsuba_mul_10b.sv
// tb/tb_karatsuba_mul_10b.sv - randomized self-checking bench for karatsuba_mul_10b
module tb_karatsuba_mul_10b;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  a, b;
  logic [19:0] s;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef KARATSUBA_PARALLEL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  karatsuba_mul_10b dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .s     (s),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operation; inputs change #1 after edges, outputs sampled #1 after edges.
  task automatic run_op(input logic [9:0] ta, input logic [9:0] tb_v, input int hold, input bit scramble);
    logic [31:0] expv;
    logic [19:0] s_seen;
    int k;
    expv  = 32'(ta) * 32'(tb_v);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    check_eq("done_low_after_accept", {31'b0, done}, 32'd0);
    if (scramble) begin
      a = 10'h155;
      b = 10'h155;
    end
    if (hold <= 1) start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k >= hold - 1) start = 1'b0;
    end
    check_eq("latency", 32'(k), 32'(LAT));
    check_eq("product", {12'b0, s}, expv);
    s_seen = s;
    start  = 1'b0;
    @(posedge clk); #1;
    check_eq("s_stable", {12'b0, s}, {12'b0, s_seen});
    check_eq("done_held", {31'b0, done}, 32'd1);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_s", {12'b0, s}, 32'd0);
    check_eq("reset_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_done", {31'b0, done}, 32'd0);

    run_op(10'h3FF, 10'h3FF, 1, 1'b0);
    check_eq("max_product", {12'b0, s}, 32'h000FF801);

    // Abort mid-operation with an asynchronous reset
    a = 10'h3FF; b = 10'h3FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_eq("midop_reset_s", {12'b0, s}, 32'd0);
    check_eq("midop_reset_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("no_done_after_abort", {31'b0, saw_done}, 32'd0);
    check_eq("idle_s_after_abort", {12'b0, s}, 32'd0);

    run_op(10'd0, 10'd1023, 2, 1'b0);
    run_op(10'h3FF, 10'h3FF, 2, 1'b0);
    run_op(10'd32, 10'd31, 1, 1'b0);
    run_op(10'd1, 10'd1, 1, 1'b0);
    run_op(10'd700, 10'd3, 1, 1'b1);
    check_eq("captured_operands", {12'b0, s}, 32'd2100);

    for (int i = 0; i < 1000; i++) begin
      run_op(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
